// File: rtl/vga_ctrl_pipe.sv
// ============================================================================
// Module      : vga_ctrl_pipe
// Description : Parametrised VGA timing generator on a pixel-clock enable.
//               It issues fetch coordinates ahead of display and delays the
//               sync, enable and marker flags to meet the returned pixel.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_ctrl_pipe #(
  parameter int   H_ACTIVE  = 640,
  parameter int   H_FP      = 16,
  parameter int   H_SYNC    = 96,
  parameter int   H_BP      = 48,
  parameter int   V_ACTIVE  = 480,
  parameter int   V_FP      = 10,
  parameter int   V_SYNC    = 2,
  parameter int   V_BP      = 33,
  parameter logic HS_POL    = 1'b0,
  parameter logic VS_POL    = 1'b0,
  parameter int   FETCH_LAT = 0,
  parameter int   COLOR_W   = 12,
  parameter int   CNT_W     = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pix_ce,
  input  logic [COLOR_W-1:0] pixel,
  output logic [CNT_W-1:0]   pix_x,
  output logic [CNT_W-1:0]   pix_y,
  output logic               pix_req,
  output logic               hs,
  output logic               vs,
  output logic               de,
  output logic [COLOR_W-1:0] rgb,
  output logic               frame_start,
  output logic               line_start
);

  localparam int c_h_total = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_v_total = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0] c_h_last   = CNT_W'(c_h_total - 1);
  localparam logic [CNT_W-1:0] c_v_last   = CNT_W'(c_v_total - 1);
  localparam logic [CNT_W-1:0] c_h_act    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] c_v_act    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] c_hs_begin = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] c_hs_end   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] c_vs_begin = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] c_vs_end   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  // Flags that travel alongside a coordinate until its pixel returns.
  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic first_px;
    logic first_col;
  } flags_t;

  logic [CNT_W-1:0] r_h_cnt;
  logic [CNT_W-1:0] r_v_cnt;
  flags_t           r_pipe [FETCH_LAT+1];

  logic   w_h_wrap;
  logic   w_v_wrap;
  flags_t w_flags;
  flags_t w_last;

  always_comb begin
    w_h_wrap           = (r_h_cnt == c_h_last);
    w_v_wrap           = (r_v_cnt == c_v_last);
    w_flags.de         = (r_h_cnt < c_h_act) && (r_v_cnt < c_v_act);
    w_flags.hs         = (r_h_cnt >= c_hs_begin) && (r_h_cnt < c_hs_end);
    w_flags.vs         = (r_v_cnt >= c_vs_begin) && (r_v_cnt < c_vs_end);
    w_flags.first_px   = (r_h_cnt == '0) && (r_v_cnt == '0);
    w_flags.first_col  = (r_h_cnt == '0) && (r_v_cnt < c_v_act);
    w_last             = r_pipe[FETCH_LAT];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      pix_x       <= '0;
      pix_y       <= '0;
      pix_req     <= 1'b0;
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      de          <= 1'b0;
      rgb         <= '0;
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      for (int i = 0; i <= FETCH_LAT; i++) begin
        r_pipe[i] <= '0;
      end
    end else begin
      // Markers are single-clk pulses even when pix_ce stays high.
      frame_start <= 1'b0;
      line_start  <= 1'b0;
      if (pix_ce) begin
        r_h_cnt <= w_h_wrap ? '0 : r_h_cnt + CNT_W'(1);
        if (w_h_wrap) begin
          r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + CNT_W'(1);
        end

        pix_x   <= r_h_cnt;
        pix_y   <= r_v_cnt;
        pix_req <= w_flags.de;

        r_pipe[0] <= w_flags;
        for (int i = 1; i <= FETCH_LAT; i++) begin
          r_pipe[i] <= r_pipe[i-1];
        end

        hs          <= w_last.hs ? HS_POL : ~HS_POL;
        vs          <= w_last.vs ? VS_POL : ~VS_POL;
        de          <= w_last.de;
        rgb         <= w_last.de ? pixel : '0;
        frame_start <= w_last.first_px;
        line_start  <= w_last.first_col;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_vga_ctrl_pipe.sv
// ============================================================================
// Module      : tb_vga_ctrl_pipe
// Description : Scoreboard bench for vga_ctrl_pipe on a reduced 16x8 raster,
//               one instance with FETCH_LAT=2 / active-low syncs and one with
//               FETCH_LAT=0 / active-high syncs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_ctrl_pipe;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic        fs;
    logic        ls;
    logic [11:0] rgb;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ce;
  logic [11:0] pixel_a;
  logic [11:0] pixel_b;
  logic [9:0]  ax, ay, bx, by;
  logic        areq, breq;
  logic        ahs, avs, ade, afs, als;
  logic        bhs, bvs, bde, bfs, bls;
  logic [11:0] argb, brgb;
  logic [11:0] src1, src2;

  int   n_vec = 0;
  int   n_err = 0;
  int   mh = 0;
  int   mv = 0;
  int   epx, epy;
  logic ereq;
  exp_t cur_a, cur_b;
  exp_t qa[$];
  exp_t qb[$];

  vga_ctrl_pipe #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b0), .VS_POL(1'b0), .FETCH_LAT(2), .COLOR_W(12), .CNT_W(10)
  ) u_dut_a (
    .clk(clk), .rst(rst), .pix_ce(ce), .pixel(pixel_a),
    .pix_x(ax), .pix_y(ay), .pix_req(areq),
    .hs(ahs), .vs(avs), .de(ade), .rgb(argb),
    .frame_start(afs), .line_start(als)
  );

  vga_ctrl_pipe #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .FETCH_LAT(0), .COLOR_W(12), .CNT_W(10)
  ) u_dut_b (
    .clk(clk), .rst(rst), .pix_ce(ce), .pixel(pixel_b),
    .pix_x(bx), .pix_y(by), .pix_req(breq),
    .hs(bhs), .vs(bvs), .de(bde), .rgb(brgb),
    .frame_start(bfs), .line_start(bls)
  );

  function automatic logic [11:0] pix_of(input logic [9:0] x, input logic [9:0] y);
    return {y[5:0], x[5:0]};
  endfunction

  // Pixel source with two registered stages for the FETCH_LAT=2 instance.
  always @(posedge clk) begin
    if (rst) begin
      src1 <= '0;
      src2 <= '0;
    end else if (ce) begin
      src1 <= pix_of(ax, ay);
      src2 <= src1;
    end
  end
  assign pixel_a = src2;
  assign pixel_b = pix_of(bx, by);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t mk(input int h, input int v, input logic hp, input logic vp);
    exp_t e;
    logic act;
    act   = (h < 8) && (v < 4);
    e.hs  = (h >= 10 && h < 13) ? hp : ~hp;
    e.vs  = (v >= 5 && v < 7) ? vp : ~vp;
    e.de  = act;
    e.fs  = (h == 0) && (v == 0);
    e.ls  = (h == 0) && (v < 4);
    e.rgb = act ? pix_of(10'(h), 10'(v)) : 12'h000;
    return e;
  endfunction

  function automatic exp_t idle(input logic hp, input logic vp);
    exp_t e;
    e     = '0;
    e.hs  = ~hp;
    e.vs  = ~vp;
    return e;
  endfunction

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, act, exp);
    end
  endtask

  task automatic step(input logic ce_v, input logic rst_v);
    logic pul;
    ce  = ce_v;
    rst = rst_v;
    @(posedge clk);
    #1;
    pul = ce_v && !rst_v;
    if (rst_v) begin
      mh = 0;
      mv = 0;
      qa.delete();
      qb.delete();
      for (int i = 0; i < 3; i++) qa.push_back(idle(1'b0, 1'b0));
      qb.push_back(idle(1'b1, 1'b1));
      cur_a = idle(1'b0, 1'b0);
      cur_b = idle(1'b1, 1'b1);
      epx   = 0;
      epy   = 0;
      ereq  = 1'b0;
    end else if (ce_v) begin
      qa.push_back(mk(mh, mv, 1'b0, 1'b0));
      qb.push_back(mk(mh, mv, 1'b1, 1'b1));
      cur_a = qa.pop_front();
      cur_b = qb.pop_front();
      epx   = mh;
      epy   = mv;
      ereq  = (mh < 8) && (mv < 4);
      if (mh == 15) begin
        mh = 0;
        mv = (mv == 7) ? 0 : mv + 1;
      end else begin
        mh = mh + 1;
      end
    end
    check_val("a_pix_x",   32'(ax),   32'(epx));
    check_val("a_pix_y",   32'(ay),   32'(epy));
    check_val("a_pix_req", 32'(areq), 32'(ereq));
    check_val("a_hs",      32'(ahs),  32'(cur_a.hs));
    check_val("a_vs",      32'(avs),  32'(cur_a.vs));
    check_val("a_de",      32'(ade),  32'(cur_a.de));
    check_val("a_rgb",     32'(argb), 32'(cur_a.rgb));
    check_val("a_frame",   32'(afs),  32'(cur_a.fs & pul));
    check_val("a_line",    32'(als),  32'(cur_a.ls & pul));
    check_val("b_pix_x",   32'(bx),   32'(epx));
    check_val("b_pix_req", 32'(breq), 32'(ereq));
    check_val("b_hs",      32'(bhs),  32'(cur_b.hs));
    check_val("b_vs",      32'(bvs),  32'(cur_b.vs));
    check_val("b_de",      32'(bde),  32'(cur_b.de));
    check_val("b_rgb",     32'(brgb), 32'(cur_b.rgb));
    check_val("b_frame",   32'(bfs),  32'(cur_b.fs & pul));
    check_val("b_line",    32'(bls),  32'(cur_b.ls & pul));
  endtask

  initial begin
    ce  = 1'b0;
    rst = 1'b1;
    // Reset hold, with pix_ce toggling underneath.
    for (int i = 0; i < 5; i++) step(i[0], 1'b1);
    // Full-rate operation over two frames.
    for (int i = 0; i < 256; i++) step(1'b1, 1'b0);
    // One tick every fourth clk for a frame.
    for (int i = 0; i < 512; i++) step((i % 4) == 3, 1'b0);
    // Irregular enable pattern.
    for (int i = 0; i < 200; i++) step($urandom_range(0, 2) != 0, 1'b0);
    // Run to mid-frame, then a single reset clk with pix_ce low.
    for (int k = 0; k < 200 && !(mv == 2 && mh == 5); k++) step(1'b1, 1'b0);
    check_val("mid_reach", 32'(mv * 16 + mh), 32'(2 * 16 + 5));
    step(1'b0, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0);
    for (int i = 0; i < 272; i++) step(1'b1, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/vga_ctrl_pipe.md
Name: vga_ctrl_pipe

Overview:
- Parametrised successor to the fixed-640x480 VGA controller.
- Generates programmable HS/VS/DE timing from a pixel-clock enable on the single system clock, so no separate divided VGA clock is needed.
- Issues pixel-fetch coordinates ahead of display to cover a configurable pixel-source latency, and presents aligned rgb/hs/vs/de plus frame/line markers.
- Sits between the framebuffer/renderer and the VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HS_POL, 0, active level of hs (0 = active-low)
- VS_POL, 0, active level of vs (0 = active-low)
- FETCH_LAT, 0, pix_ce ticks from pix_x/pix_y change to pixel valid (0..7)
- COLOR_W, 12, rgb/pixel width
- CNT_W, 10, counter/coordinate width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous reset, active-high
- pix_ce  in  1  pixel tick enable; all state advances only when high
- pixel  in  COLOR_W  pixel data for the last-requested coordinate
- pix_x  out  CNT_W  fetch x coordinate
- pix_y  out  CNT_W  fetch y coordinate
- pix_req  out  1  fetch coordinate lies in the active area
- hs  out  1  horizontal sync
- vs  out  1  vertical sync
- de  out  1  display enable, aligned with rgb
- rgb  out  COLOR_W  output colour; 0 when de=0
- frame_start  out  1  one-clk pulse when rgb carries pixel (0,0)
- line_start  out  1  one-clk pulse when rgb carries x=0 of any active line

Behaviour:
- Derived constants: H_TOTAL = sum of the four H parameters; V_TOTAL likewise.
- Reset (rst=1 at a clk edge, regardless of pix_ce):
  - h_cnt and v_cnt = 0; pix_x, pix_y = 0; pix_req = 0; de = 0; rgb = 0.
  - hs = ~HS_POL, vs = ~VS_POL; frame_start = line_start = 0.
  - All delay-pipe stages are cleared to inactive values.
- Counters, on each pix_ce tick:
  - h_cnt = (h_cnt == H_TOTAL-1) ? 0 : h_cnt+1.
  - v_cnt increments (wrapping at V_TOTAL-1 -> 0) only on the tick where h_cnt wraps.
- Fetch stage: registered on each pix_ce tick from the current (h_cnt, v_cnt).
  - pix_x = h_cnt, pix_y = v_cnt.
  - pix_req = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - pix_x/pix_y are driven in blanking too; consumers ignore them while pix_req=0.
- Timing decode from the same counter state:
  - hs_raw active when H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vs_raw active when V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC; vs changes only at line boundaries.
  - de_raw = pix_req condition.
- Alignment:
  - hs_raw, vs_raw, de_raw, first-pixel and first-column flags pass through a FETCH_LAT+1 stage delay pipe, advancing on pix_ce.
  - Outputs for a coordinate appear FETCH_LAT+1 pix_ce ticks after that coordinate appears on pix_x/pix_y.
  - rgb is registered on that same tick: rgb = de_pipe ? pixel : 0, so pixel is sampled exactly FETCH_LAT ticks after the request.
- Polarity: hs = hs_pipe ? HS_POL : ~HS_POL; vs likewise with VS_POL.
- frame_start / line_start: high for exactly one clk (the clk of the pix_ce tick that updates rgb), then 0 on the next clk even if pix_ce stays high. Not asserted during blanking lines.
- pix_ce low: every output and register holds its value; no pulses are generated.
- pix_ce tied high: the block runs at full clk rate.
- Reset mid-frame: the timing restarts at (0,0). The first de after release comes FETCH_LAT+1 ticks after the first tick, with a frame_start pulse.
- No partial frames are emitted before that point.

Test Plan:
- Reset hold: rst=1 for 5 clks, HS_POL=VS_POL=0 -> hs=1, vs=1, de=0, rgb=0, pix_x=pix_y=0, no pulses.
- Small timing, pix_ce=1: H 8/2/3/3, V 4/1/2/1, FETCH_LAT=0, pixel={pix_y,pix_x} truncated.
  - hs low for 3 of every 16 clks starting 11 clks after each line's x=0 request.
  - vs low for exactly 32 clks per 128-clk frame.
  - de high for 8 clks per active line, 4 lines per frame.
  - rgb matches the delayed coordinate.
- pix_ce every 4th clk, default 640x480 timing:
  - Line period 3200 clks, frame period 1,680,000 clks.
  - Outputs change only on ce clks; frame_start pulse 1 clk wide.
- FETCH_LAT=2, model source registers pix_x twice:
  - rgb equals the pixel for (x,y) when de asserts.
  - First de of a line is 3 ticks after pix_x=0 with pix_req=1.
  - No off-by-one column.
- HS_POL=1, VS_POL=1 -> sync pulses active-high with identical widths and positions; reset value hs=vs=0.
- rst asserted at line 200, x=300 for 1 clk:
  - Next pix_ce tick pix_x=0, pix_y=0.
  - frame_start fires FETCH_LAT+1 ticks later.
  - Line count to the next frame_start is V_TOTAL.
